fgmt_ibuf: RTL

Per-thread instruction buffer for the fine-grained multithreaded fetch stage. One instance per hardware thread context, selected by `CTID`. It holds `NUM_LINES` fully-associative instruction lines of `LINE_WORDS` words each. It serves fetches combinationally and refills from L2 over a valid/ready request channel plus a thread-tagged response bus. It replaces the single-line-per-thread buffer with multi-line storage, victim selection, a one-outstanding-miss FSM, flush, and optional next-line prefetch.

---
 rtl/fgmt_ibuf.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/fgmt_ibuf.sv
//------------------------------------------------------------------------------
// Module      : fgmt_ibuf
// Description : Per-thread multi-line instruction buffer with a single
//               outstanding L2 refill. Optional next-line prefetch is
//               enabled by defining FGMT_IBUF_PREFETCH_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fgmt_ibuf #(
  parameter int          CTID       = 0,
  parameter int          TID_BITS   = 2,
  parameter int          NUM_LINES  = 4,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] BUBBLE     = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TID_BITS-1:0]      TID_fetch,
  input  logic [31:0]              PCF,
  input  logic                     flush,
  output logic                     hit,
  output logic [31:0]              instr,
  output logic                     busy,
  output logic                     l2_req_valid,
  input  logic                     l2_req_ready,
  output logic [31:0]              l2_req_addr,
  output logic [TID_BITS-1:0]      l2_req_tid,
  input  logic                     l2_rsp_valid,
  input  logic [TID_BITS-1:0]      l2_rsp_tid,
  input  logic [31:0]              l2_rsp_addr,
  input  logic [32*LINE_WORDS-1:0] l2_rsp_data
);

  localparam int c_off    = $clog2(LINE_WORDS) + 2;
  localparam int c_tag_w  = 32 - c_off;
  localparam int c_idx_w  = $clog2(NUM_LINES);
  localparam int c_ws_w   = $clog2(LINE_WORDS);
  localparam int c_line_w = 32 * LINE_WORDS;
  localparam logic [TID_BITS-1:0] c_ctid = TID_BITS'(CTID);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_LINES-1:0]  r_valid;
  logic [c_tag_w-1:0]    r_tag  [NUM_LINES];
  logic [c_line_w-1:0]   r_data [NUM_LINES];
  logic [c_idx_w-1:0]    r_rr;
  logic [31:0]           r_miss_addr;
  logic [31:0]           w_miss_addr_nxt;
  logic                  r_discard;
  logic                  w_discard_nxt;

  logic                  w_active;
  logic [c_tag_w-1:0]    w_pc_tag;
  logic [c_ws_w-1:0]     w_wsel;
  logic                  w_match;
  logic [c_idx_w-1:0]    w_hit_idx;
  logic [c_line_w-1:0]   w_line;
  logic                  w_has_inv;
  logic [c_idx_w-1:0]    w_inv_idx;
  logic [c_idx_w-1:0]    w_victim;
  logic                  w_accept;
  logic                  w_fill;
  logic                  w_unused_bits;

  assign w_active = (TID_fetch == c_ctid);
  assign w_pc_tag = PCF[31:c_off];
  assign w_wsel   = PCF[c_off-1:2];

  // Fully-associative tag match; tags are unique so at most one entry hits.
  always_comb begin
    w_match   = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (r_valid[i] && (r_tag[i] == w_pc_tag)) begin
        w_match   = 1'b1;
        w_hit_idx = c_idx_w'(i);
      end
    end
  end

  assign w_line = r_data[w_hit_idx];
  assign hit    = w_active & w_match;
  assign instr  = hit ? w_line[{w_wsel, 5'd0} +: 32] : BUBBLE;

  // Lowest-index invalid entry wins; scanning downward leaves the lowest last.
  always_comb begin
    w_has_inv = 1'b0;
    w_inv_idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_has_inv = 1'b1;
        w_inv_idx = c_idx_w'(i);
      end
    end
  end

  assign w_victim = w_has_inv ? w_inv_idx : r_rr;

  assign w_accept = (r_state == S_WAIT) && l2_rsp_valid && (l2_rsp_tid == c_ctid) &&
                    (l2_rsp_addr[31:c_off] == r_miss_addr[31:c_off]);
  assign w_fill   = w_accept && !r_discard && !flush;

`ifdef FGMT_IBUF_PREFETCH_EN
  logic [c_tag_w-1:0] w_nxt_tag;
  logic               w_nxt_present;
  logic               w_pf_req;

  assign w_nxt_tag = w_pc_tag + 1'b1;

  always_comb begin
    w_nxt_present = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (r_valid[i] && (r_tag[i] == w_nxt_tag)) w_nxt_present = 1'b1;
    end
  end

  assign w_pf_req = w_active && w_match && (w_wsel == c_ws_w'(LINE_WORDS - 1)) && !w_nxt_present;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_miss_addr_nxt = r_miss_addr;
    w_discard_nxt   = r_discard;
    case (r_state)
      S_IDLE: begin
        if (w_active && !w_match) begin
          w_state_nxt     = S_REQ;
          w_miss_addr_nxt = {w_pc_tag, {c_off{1'b0}}};
        end
`ifdef FGMT_IBUF_PREFETCH_EN
        else if (w_pf_req) begin
          w_state_nxt     = S_REQ;
          w_miss_addr_nxt = {w_nxt_tag, {c_off{1'b0}}};
        end
`endif
      end
      S_REQ: begin
        if (flush)        w_discard_nxt = 1'b1;
        if (l2_req_ready) w_state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        if (flush) w_discard_nxt = 1'b1;
        if (w_accept) begin
          w_discard_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_discard_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_miss_addr <= '0;
      r_discard   <= 1'b0;
      r_valid     <= '0;
      r_rr        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_miss_addr <= w_miss_addr_nxt;
      r_discard   <= w_discard_nxt;
      if (flush) begin
        r_valid <= '0;
      end else if (w_fill) begin
        r_valid[w_victim] <= 1'b1;
        if (!w_has_inv) r_rr <= r_rr + 1'b1;
      end
    end
  end

  // Line payload needs no reset; it is qualified by r_valid.
  always_ff @(posedge clk) begin
    if (!reset && w_fill) begin
      r_tag[w_victim]  <= l2_rsp_addr[31:c_off];
      r_data[w_victim] <= l2_rsp_data;
    end
  end

  assign l2_req_valid = (r_state == S_REQ);
  assign l2_req_addr  = r_miss_addr;
  assign l2_req_tid   = c_ctid;
  assign busy         = (r_state != S_IDLE);

  assign w_unused_bits = ^{PCF[1:0], l2_rsp_addr[c_off-1:0]};

endmodule

`default_nettype wire
